// File: rtl/hamming74_pkg.sv
// Shared types, widths and the round-robin pick helper
// for the Hamming(7,4) encoder arbiter.
package hamming74_pkg;

  localparam int NIB_W  = 4;
  localparam int CW_W   = 7;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } arb_state_t;

  // First set bit of vld searching upward from ptr,
  // wrapping at n (n <= 8, ptr < n).
  function automatic logic [2:0] rr_pick(
    input logic [7:0] vld,
    input logic [2:0] ptr,
    input logic [3:0] n
  );
    logic [2:0] res;
    logic       hit;
    logic [3:0] idx;
    res = '0;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= n) idx = idx - n;
      if (!hit && (i < int'(n)) && vld[idx[2:0]]) begin
        res = idx[2:0];
        hit = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming74_encoder.sv
// Hamming(7,4) encoder: data nibble in [3:0],
// parity bits in [6:4].
module hamming74_encoder
  import hamming74_pkg::*;
(
  input  logic [NIB_W-1:0] data_i,
  output logic [CW_W-1:0]  cw_o
);

  logic d0, d1, d2, d3;

  assign {d3, d2, d1, d0} = data_i;

  assign cw_o = {
    d1 ^ d2 ^ d3,
    d0 ^ d2 ^ d3,
    d0 ^ d1 ^ d3,
    data_i
  };

endmodule

// File: rtl/hamming74_enc_arbiter.sv
// Round-robin arbiter sharing one Hamming(7,4) encoder
// among byte requesters; emits low then high nibble codewords.
module hamming74_enc_arbiter
  import hamming74_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [8*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  cw_valid,
  output logic [CW_W-1:0]       cw_data,
  output logic [ID_W-1:0]       cw_id,
  output logic                  cw_last,
  input  logic                  cw_ready
);

  arb_state_t        state_q, state_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   pick, ptr_nxt;
  logic [BYTE_W-1:0] sel_byte;
  logic              any_vld;
  logic              accept;
  logic [NIB_W-1:0]  enc_in;
  logic [CW_W-1:0]   enc_out;

  assign any_vld = |req_valid;

  assign pick = ID_W'(rr_pick(8'(req_valid),
                              3'(ptr_q),
                              4'(NUM_REQ)));

  assign ptr_nxt = (pick == ID_W'(NUM_REQ - 1))
                 ? '0 : pick + ID_W'(1);

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == ID_W'(i)) sel_byte = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    accept   = 1'b0;
    cw_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        accept = any_vld;
      end
      LO: begin
        cw_valid = 1'b1;
        if (cw_ready) state_d = HI;
      end
      HI: begin
        cw_valid = 1'b1;
        if (cw_ready) begin
          state_d = IDLE;
          accept  = any_vld;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new byte always enters at its low nibble.
    if (accept) begin
      byte_d  = sel_byte;
      gnt_d   = pick;
      ptr_d   = ptr_nxt;
      state_d = LO;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (pick == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign enc_in = (state_q == HI) ? byte_q[7:4]
                                  : byte_q[3:0];

  hamming74_encoder u_enc (
    .data_i (enc_in),
    .cw_o   (enc_out)
  );

  assign cw_data = enc_out;
  assign cw_id   = gnt_q;
  assign cw_last = (state_q == HI);

endmodule

// File: tb/tb_hamming74_enc_arbiter.sv
// Directed table, hand sequences and a queue-based
// random model for hamming74_enc_arbiter.
module tb_hamming74_enc_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [1:0]  v;
  logic [15:0] d;
  logic [1:0]  rr;
  logic        cv;
  logic [6:0]  cd;
  logic        ci;
  logic        cl;
  logic        rdy;

  logic [2:0]  v3;
  logic [23:0] d3;
  logic [2:0]  rr3;
  logic        cv3;
  logic [6:0]  cd3;
  logic [1:0]  ci3;
  logic        cl3;
  logic        rdy3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hamming74_enc_arbiter #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (v),
    .req_data  (d),
    .req_ready (rr),
    .cw_valid  (cv),
    .cw_data   (cd),
    .cw_id     (ci),
    .cw_last   (cl),
    .cw_ready  (rdy)
  );

  hamming74_enc_arbiter #(.NUM_REQ(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (v3),
    .req_data  (d3),
    .req_ready (rr3),
    .cw_valid  (cv3),
    .cw_data   (cd3),
    .cw_id     (ci3),
    .cw_last   (cl3),
    .cw_ready  (rdy3)
  );

  typedef struct {
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic       ev;
    logic       chk;
    logic [6:0] ed;
    logic       eid;
    logic       el;
    logic [1:0] er;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] vv, input logic [7:0] a,
                     input logic [7:0] b, input logic r,
                     input logic ev, input logic c,
                     input logic [6:0] ed, input logic eid,
                     input logic el, input logic [1:0] er);
    vec_t t;
    t.v = vv; t.d0 = a; t.d1 = b; t.rdy = r;
    t.ev = ev; t.chk = c; t.ed = ed; t.eid = eid;
    t.el = el; t.er = er;
    tbl.push_back(t);
  endtask

  // Reference encoder straight from the parity equations.
  function automatic int enc(input int nib);
    int b0, b1, b2, b3;
    b0 = nib & 1;
    b1 = (nib >> 1) & 1;
    b2 = (nib >> 2) & 1;
    b3 = (nib >> 3) & 1;
    return (nib & 15)
         | ((b0 ^ b1 ^ b3) << 4)
         | ((b0 ^ b2 ^ b3) << 5)
         | ((b1 ^ b2 ^ b3) << 6);
  endfunction

  function automatic int m_pick(input logic [1:0] vv, input int p);
    for (int k = 0; k < 2; k++) begin
      if (vv[(p + k) % 2]) return (p + k) % 2;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    v = '0; d = '0; rdy = 1'b0;
    v3 = '0; d3 = '0; rdy3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int q[$];
    int ptr;
    int p;
    bit acc;
    int exp_r;

    rst_n = 1'b0;
    v = '0; d = '0; rdy = 1'b0;
    v3 = '0; d3 = '0; rdy3 = 1'b0;

    // reset state
    add(2'b00, 8'h00, 8'h00, 1, 0, 1, 7'h00, 0, 0, 2'b00);
    // single byte 0xB5 from req0
    add(2'b01, 8'hB5, 8'h00, 1, 0, 1, 7'h00, 0, 0, 2'b01);
    add(2'b00, 8'h00, 8'h00, 1, 1, 1, 7'h55, 0, 0, 2'b00);
    add(2'b00, 8'h00, 8'h00, 1, 1, 1, 7'h1B, 0, 1, 2'b00);
    add(2'b00, 8'h00, 8'h00, 1, 0, 0, 7'h00, 0, 0, 2'b00);
    // nibble extremes 0xF0, 0x0F from req1, back-to-back
    add(2'b10, 8'h00, 8'hF0, 1, 0, 0, 7'h00, 0, 0, 2'b10);
    add(2'b10, 8'h00, 8'h0F, 1, 1, 1, 7'h00, 1, 0, 2'b00);
    add(2'b10, 8'h00, 8'h0F, 1, 1, 1, 7'h7F, 1, 1, 2'b10);
    add(2'b00, 8'h00, 8'h00, 1, 1, 1, 7'h7F, 1, 0, 2'b00);
    add(2'b00, 8'h00, 8'h00, 1, 1, 1, 7'h00, 1, 1, 2'b00);
    add(2'b00, 8'h00, 8'h00, 1, 0, 0, 7'h00, 0, 0, 2'b00);
    // fairness: both valid continuously
    add(2'b11, 8'hA1, 8'h3C, 1, 0, 0, 7'h00, 0, 0, 2'b01);
    add(2'b11, 8'hA1, 8'h3C, 1, 1, 1, 7'h31, 0, 0, 2'b00);
    add(2'b11, 8'hA1, 8'h3C, 1, 1, 1, 7'h2A, 0, 1, 2'b10);
    add(2'b11, 8'hA1, 8'h3C, 1, 1, 1, 7'h1C, 1, 0, 2'b00);
    add(2'b11, 8'hA1, 8'h3C, 1, 1, 1, 7'h63, 1, 1, 2'b01);
    add(2'b11, 8'hA1, 8'h3C, 1, 1, 1, 7'h31, 0, 0, 2'b00);
    add(2'b11, 8'hA1, 8'h3C, 1, 1, 1, 7'h2A, 0, 1, 2'b10);
    add(2'b11, 8'hA1, 8'h3C, 1, 1, 1, 7'h1C, 1, 0, 2'b00);
    add(2'b11, 8'hA1, 8'h3C, 1, 1, 1, 7'h63, 1, 1, 2'b01);
    add(2'b00, 8'h00, 8'h00, 1, 1, 1, 7'h31, 0, 0, 2'b00);
    add(2'b00, 8'h00, 8'h00, 1, 1, 1, 7'h2A, 0, 1, 2'b00);
    // backpressure in LO with 0xB5 (req1 is next in turn)
    add(2'b10, 8'h00, 8'hB5, 0, 0, 0, 7'h00, 0, 0, 2'b10);
    add(2'b00, 8'h00, 8'h00, 0, 1, 1, 7'h55, 1, 0, 2'b00);
    add(2'b00, 8'h00, 8'h00, 0, 1, 1, 7'h55, 1, 0, 2'b00);
    add(2'b00, 8'h00, 8'h00, 0, 1, 1, 7'h55, 1, 0, 2'b00);
    add(2'b00, 8'h00, 8'h00, 1, 1, 1, 7'h55, 1, 0, 2'b00);
    // backpressure in HI with a pending request
    add(2'b01, 8'h00, 8'h00, 0, 1, 1, 7'h1B, 1, 1, 2'b00);
    add(2'b01, 8'h00, 8'h00, 1, 1, 1, 7'h1B, 1, 1, 2'b01);
    add(2'b00, 8'h00, 8'h00, 1, 1, 1, 7'h00, 0, 0, 2'b00);
    add(2'b00, 8'h00, 8'h00, 1, 1, 1, 7'h00, 0, 1, 2'b00);
    add(2'b00, 8'h00, 8'h00, 1, 0, 0, 7'h00, 0, 0, 2'b00);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      v = tbl[i].v;
      d = {tbl[i].d1, tbl[i].d0};
      rdy = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d.valid", i), int'(cv), int'(tbl[i].ev));
      chk($sformatf("row%0d.ready", i), int'(rr), int'(tbl[i].er));
      if (tbl[i].chk) begin
        chk($sformatf("row%0d.data", i), int'(cd), int'(tbl[i].ed));
        chk($sformatf("row%0d.id", i), int'(ci), int'(tbl[i].eid));
        chk($sformatf("row%0d.last", i), int'(cl), int'(tbl[i].el));
      end
    end

    // reset while in HI aborts the byte
    @(negedge clk);
    v = 2'b01; d = 16'h00B5; rdy = 1'b1;
    #1 chk("rst.acc", int'(rr), 1);
    @(negedge clk);
    v = 2'b00;
    #1 chk("rst.lo", int'(cd), 'h55);
    @(negedge clk);
    #1 chk("rst.inhi", int'(cl), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.valid", int'(cv), 0);
    chk("rst.data", int'(cd), 0);
    chk("rst.id", int'(ci), 0);
    chk("rst.last", int'(cl), 0);
    chk("rst.ready", int'(rr), 0);
    @(negedge clk);
    v = 2'b11; d = 16'hA13C;
    #1 chk("rst.grant0", int'(rr), 1);
    @(negedge clk);
    v = 2'b00;
    #1;
    chk("rst.newlo", int'(cd), 'h1C);
    chk("rst.newid", int'(ci), 0);
    @(negedge clk);
    #1 chk("rst.newhi", int'(cd), 'h63);
    @(negedge clk);
    #1 chk("rst.idle", int'(cv), 0);

    // randomized run against a codeword-queue model
    do_reset();
    ptr = 0;
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk);
      v = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      p = m_pick(v, ptr);
      acc = (v != 0) &&
            (q.size() == 0 || (q.size() == 1 && rdy));
      exp_r = acc ? (1 << p) : 0;
      #1;
      chk("rnd.ready", int'(rr), exp_r);
      chk("rnd.valid", int'(cv), int'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rnd.cw", {int'(cl), int'(ci), int'(cd)}, q[0]);
      end
      @(posedge clk);
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (acc) begin
        q.push_back({0, p, enc(int'(d[8*p +: 4]))});
        q.push_back({1, p, enc(int'(d[8*p+4 +: 4]))});
        ptr = (p + 1) % 2;
      end
    end

    // pointer wrap on the three-requester instance
    do_reset();
    @(negedge clk);
    v3 = 3'b100; d3 = 24'h5B0000; rdy3 = 1'b1;
    #1 chk("wrap.acc2", int'(rr3), 4);
    @(negedge clk);
    v3 = 3'b000;
    #1;
    chk("wrap.lo2", int'(cd3), 'h1B);
    chk("wrap.id2lo", int'(ci3), 2);
    @(negedge clk);
    v3 = 3'b011; d3 = 24'h0077B5;
    #1;
    chk("wrap.hi2", int'(cd3), 'h55);
    chk("wrap.id2hi", int'(ci3), 2);
    chk("wrap.acc0", int'(rr3), 1);
    @(negedge clk);
    v3 = 3'b000;
    #1;
    chk("wrap.lo0", int'(cd3), 'h55);
    chk("wrap.id0lo", int'(ci3), 0);
    @(negedge clk);
    #1;
    chk("wrap.hi0", int'(cd3), 'h1B);
    chk("wrap.id0hi", int'(ci3), 0);
    chk("wrap.last", int'(cl3), 1);
    @(negedge clk);
    #1 chk("wrap.idle", int'(cv3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming74_enc_arbiter.md
# hamming74_enc_arbiter

Round-robin arbiter and sequencer that shares one Hamming(7,4) encoder among `NUM_REQ` byte-wide requesters. Each accepted byte is split into low then high nibble, and each nibble is emitted as a 7-bit codeword tagged with the source ID over a valid/ready output channel. The block sits between the byte producers and the channel serializer.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: source-ID width.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in `NUM_REQ`: per-requester byte valid.
- `req_data` in `8*NUM_REQ`: requester i's byte is at `[8*i+7:8*i]`.
- `req_ready` out `NUM_REQ`: one-hot accept. At most one bit is high.
- `cw_valid` out 1: codeword valid.
- `cw_data` out 7: codeword. Bits [3:0] are the nibble, [4]=d0^d1^d3, [5]=d0^d2^d3, [6]=d1^d2^d3.
- `cw_id` out `ID_W`: source requester of the codeword.
- `cw_last` out 1: high on the high-nibble codeword.
- `cw_ready` in 1: downstream accept.

## Operation
- State machine has three states: IDLE, LO, HI. State bits are `state`, byte register `byte_q`, grant register `gnt_q`, and pointer `ptr`.
- **Pick:** the requester granted is the first i with `req_valid[i]`, searching from `ptr` upward with wrap-around.
- **IDLE:** if any `req_valid` is high, assert `req_ready[pick]`. On that edge, capture the byte into `byte_q`, capture `pick` into `gnt_q`, set `ptr = (pick+1) mod NUM_REQ`, and go to LO. Otherwise stay in IDLE with all `req_ready` low.
- **LO:** `cw_valid`=1, `cw_data`=enc(`byte_q[3:0]`), `cw_id`=`gnt_q`, `cw_last`=0. On `cw_ready`, go to HI.
- **HI:** `cw_valid`=1, `cw_data`=enc(`byte_q[7:4]`), `cw_last`=1.
  - On `cw_ready` with some `req_valid` high: assert `req_ready[pick]` in the same cycle, capture the new byte, grant and pointer, and go to LO. This is back-to-back operation.
  - On `cw_ready` with no `req_valid`: go to IDLE.
  - Without `cw_ready`: hold.
- **`req_ready`** is combinational from state, `cw_ready` and `req_valid`. Requesters must not gate `req_valid` on `req_ready`.
- **Output stability:** `cw_data`, `cw_id` and `cw_last` are driven only from registers through the encoder. While `cw_valid` is high and `cw_ready` is low, they stay stable.
- **Simultaneous requests:** resolved by the round-robin rule alone. There is no priority override.
- **Requester dropping valid:** a requester that drops `req_valid` before being accepted loses nothing; no state is recorded for it.

## Timing
- **Reset values:** state=IDLE, `ptr`=0, `byte_q`=0, `gnt_q`=0. `cw_valid`=0, `cw_data`=0, `cw_id`=0, `cw_last`=0, `req_ready`=0.
- **Reset mid-operation:** `rst_n` low at any edge aborts. Any partially sent byte is dropped with no further codeword. The first grant after release goes to the lowest valid index at or above 0.
- **Latency:** accept at edge t puts the low codeword valid in cycle t+1. The high codeword is valid at the earliest in cycle t+2.
- **Throughput:** sustained rate is 1 byte per 2 cycles with `cw_ready` held high. The next accept coincides with the high-nibble handshake edge.
- **Output gaps:** there are no bubbles between bytes when requests are pending. From IDLE there is a one-cycle gap: accept edge, then LO.

## Structure
- **Package `hamming74_pkg`:**
  - constants `NIB_W`=4, `CW_W`=7, `BYTE_W`=8
  - enum `arb_state_t` {IDLE, LO, HI}
- **Encoder:** a single instance of the existing `hamming74_encoder` (4-bit in, 7-bit out). Its input is muxed by state between `byte_q[3:0]` and `byte_q[7:4]`.
- **Round-robin pick:** implemented as a function in the package. No further sub-module.

## Test plan
- **Single byte:** req0 sends 0xB5, `cw_ready`=1. Expect codeword 0x55 (id0, last0) in cycle t+1, then 0x1B (id0, last1) in t+2, then `cw_valid`=0.
- **Nibble extremes:** bytes 0xF0 then 0x0F back-to-back from req1. Expect 0x00, 0x7F, 0x7F, 0x00 on four consecutive cycles, all id1, with `req_ready[1]` pulsed on the second codeword's edge.
- **Fairness:** both requesters hold `req_valid`=1 continuously. Expect IDs 0,0,1,1,0,0,1,1 and `req_ready` alternating, one bit at a time.
- **Backpressure:** hold `cw_ready`=0 for 3 cycles during LO with byte 0xB5. Expect `cw_data`=0x55, id and last stable, no `req_ready`. Release, then see 0x1B.
- **Reset mid-byte:** pulse `rst_n` low for 1 cycle while in HI. Expect all outputs 0 the next cycle, and no high codeword for the aborted byte. With req1 and req0 both then valid, the first grant goes to req0.
- **Pointer wrap with `NUM_REQ`=3:** only req2 valid, then only req0. Expect grants 2 then 0, with `ptr` wrapping 0→... and the ID correct on all codewords.
